// File: rtl/env_pkg.sv
// env_pkg: definitions shared by envelope_bank and envelope_channel.
//   env_dir_t     : envelope direction (ENV_SUB = count down, ENV_ADD = count up)
//   presc_width() : prescaler counter width for a given clk-per-tick divisor
//   vol_max()     : saturation value for a given volume width, {w{1'b1}}
package env_pkg;

   typedef enum logic {
      ENV_SUB = 1'b0,
      ENV_ADD = 1'b1
   } env_dir_t;

   function automatic int unsigned presc_width(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

   function automatic int unsigned vol_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/envelope_channel.sv
// envelope_channel: one volume envelope (timer, volume, saturation flag).
//   clk, reset       : clock, asynchronous active-high clear
//   env_tick         : 1-cycle envelope tick from the shared prescaler
//   trigger          : restart pulse; reloads volume/timer and clears done
//   envelope_add     : 1 = step volume up, 0 = step down
//   period           : ticks per step; 0 = hold mode
//   starting_volume  : volume loaded on trigger
//   volume, done     : registered volume and saturation flag
//   dac_on           : combinational, low when start volume is 0 and direction is down
module envelope_channel
   import env_pkg::*;
#(
   parameter int unsigned VOL_W = 4,
   parameter int unsigned PER_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             env_tick,
   input  logic             trigger,
   input  logic             envelope_add,
   input  logic [PER_W-1:0] period,
   input  logic [VOL_W-1:0] starting_volume,
   output logic [VOL_W-1:0] volume,
   output logic             done,
   output logic             dac_on
);

   localparam logic [VOL_W-1:0] VOL_MAX = VOL_W'(vol_max(VOL_W));

   env_dir_t         dir;
   logic [PER_W-1:0] timer;
   // Set by the first trigger after reset; keeps an untriggered channel at 0
   // instead of stepping (and saturating) from its cleared state.
   logic             armed;
   logic             step_en;
   logic             reload;
   logic             at_limit;

   assign dir = env_dir_t'(envelope_add);

   always_comb begin
      step_en  = env_tick && armed && !done && (period != '0);
      reload   = (timer <= PER_W'(1));
      at_limit = (dir == ENV_ADD) ? (volume == VOL_MAX) : (volume == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer  <= '0;
         volume <= '0;
         done   <= 1'b0;
         armed  <= 1'b0;
      end else if (trigger) begin
         timer  <= period;
         volume <= starting_volume;
         done   <= 1'b0;
         armed  <= 1'b1;
      end else if (step_en) begin
         if (!reload) begin
            timer <= timer - PER_W'(1);
         end else begin
            timer <= period;
            if (at_limit)
               done <= 1'b1;
            else if (dir == ENV_ADD)
               volume <= volume + VOL_W'(1);
            else
               volume <= volume - VOL_W'(1);
         end
      end
   end

   assign dac_on = (starting_volume != '0) || (dir == ENV_ADD);

endmodule

// File: rtl/envelope_bank.sv
// envelope_bank: NUM_CH independent volume envelopes sharing one tick prescaler.
//   clk, reset       : clock, asynchronous active-high clear
//   trigger          : per-channel restart pulse
//   envelope_add     : per-channel direction (1 = up)
//   period           : packed per-channel period, channel i at [i*PER_W +: PER_W]
//   starting_volume  : packed per-channel start volume, channel i at [i*VOL_W +: VOL_W]
//   volume           : packed per-channel registered volume
//   done             : per-channel saturation flag
//   dac_on           : per-channel DAC enable (combinational from inputs)
module envelope_bank
   import env_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned VOL_W    = 4,
   parameter int unsigned PER_W    = 3,
   parameter int unsigned TICK_DIV = 8192
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       trigger,
   input  logic [NUM_CH-1:0]       envelope_add,
   input  logic [NUM_CH*PER_W-1:0] period,
   input  logic [NUM_CH*VOL_W-1:0] starting_volume,
   output logic [NUM_CH*VOL_W-1:0] volume,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       dac_on
);

   localparam int unsigned PS_W = presc_width(TICK_DIV);

   logic [PS_W-1:0] presc;
   logic            env_tick;

   assign env_tick = (presc == PS_W'(TICK_DIV - 1));

   // Free-running; triggers never disturb the tick phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         presc <= '0;
      else if (env_tick)
         presc <= '0;
      else
         presc <= presc + PS_W'(1);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      envelope_channel #(
         .VOL_W (VOL_W),
         .PER_W (PER_W)
      ) u_ch (
         .clk             (clk),
         .reset           (reset),
         .env_tick        (env_tick),
         .trigger         (trigger[i]),
         .envelope_add    (envelope_add[i]),
         .period          (period[i*PER_W +: PER_W]),
         .starting_volume (starting_volume[i*VOL_W +: VOL_W]),
         .volume          (volume[i*VOL_W +: VOL_W]),
         .done            (done[i]),
         .dac_on          (dac_on[i])
      );
   end

endmodule

// File: tb/tb_envelope_bank.sv
module tb_envelope_bank;

   localparam int NCH  = 4;
   localparam int VW   = 4;
   localparam int PW   = 3;
   localparam int TD   = 4;
   localparam int VMAX = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    trigger;
   logic [NCH-1:0]    envelope_add;
   logic [NCH*PW-1:0] period;
   logic [NCH*VW-1:0] starting_volume;
   logic [NCH*VW-1:0] volume;
   logic [NCH-1:0]    done;
   logic [NCH-1:0]    dac_on;

   int checks   = 0;
   int failures = 0;
   bit live_chk = 1'b0;

   // Reference model: tick phase, and per channel the volume, done flag,
   // whether it has been triggered, ticks since the last step and the
   // step length latched at the last (re)load.
   int pc;
   int m_vol[NCH];
   bit m_done[NCH];
   bit m_act[NCH];
   int m_elapsed[NCH];
   int m_span[NCH];

   envelope_bank #(
      .NUM_CH   (NCH),
      .VOL_W    (VW),
      .PER_W    (PW),
      .TICK_DIV (TD)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .trigger         (trigger),
      .envelope_add    (envelope_add),
      .period          (period),
      .starting_volume (starting_volume),
      .volume          (volume),
      .done            (done),
      .dac_on          (dac_on)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int vol_of(input int ch);
      return int'(volume[ch*VW +: VW]);
   endfunction

   function automatic int per_of(input int ch);
      return int'(period[ch*PW +: PW]);
   endfunction

   function automatic int start_of(input int ch);
      return int'(starting_volume[ch*VW +: VW]);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pc = 0;
         for (int c = 0; c < NCH; c++) begin
            m_vol[c] = 0; m_done[c] = 0; m_act[c] = 0;
            m_elapsed[c] = 0; m_span[c] = 0;
         end
      end else begin
         bit tick;
         tick = (pc == TD - 1);
         pc   = (pc + 1) % TD;
         for (int c = 0; c < NCH; c++) begin
            if (trigger[c]) begin
               m_vol[c] = start_of(c); m_done[c] = 0; m_act[c] = 1;
               m_elapsed[c] = 0; m_span[c] = per_of(c);
            end else if (tick && m_act[c] && !m_done[c] && per_of(c) != 0) begin
               m_elapsed[c]++;
               if (m_elapsed[c] >= m_span[c]) begin
                  m_elapsed[c] = 0;
                  m_span[c] = per_of(c);
                  if (envelope_add[c]) begin
                     if (m_vol[c] == VMAX) m_done[c] = 1; else m_vol[c]++;
                  end else begin
                     if (m_vol[c] == 0) m_done[c] = 1; else m_vol[c]--;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (live_chk) begin
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("model_vol%0d", c), vol_of(c), m_vol[c]);
            check($sformatf("model_done%0d", c), done[c], m_done[c]);
            check($sformatf("model_dac%0d", c), dac_on[c],
                  (start_of(c) != 0 || envelope_add[c]) ? 1 : 0);
         end
      end
   end

   task automatic set_ch(input int ch, input bit add, input int per, input int st);
      envelope_add[ch]           = add;
      period[ch*PW +: PW]        = PW'(per);
      starting_volume[ch*VW +: VW] = VW'(st);
   endtask

   task automatic pulse(input logic [NCH-1:0] mask);
      trigger = mask;
      @(negedge clk);
      trigger = '0;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TD) @(negedge clk);
   endtask

   task automatic wait_model_vol(input int ch, input int v, input int max_cyc);
      for (int i = 0; i < max_cyc && m_vol[ch] != v; i++) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      trigger = '0; envelope_add = '0; period = '0; starting_volume = '0;
      repeat (2) @(negedge clk);
      check("reset_vol", volume, 0);
      check("reset_done", done, 0);
      reset = 1'b0;
      live_chk = 1'b1;
      wait_ticks(3);
      check("idle_vol", volume, 0);
      check("idle_done", done, 0);

      // 1: down from F, period 1
      set_ch(0, 0, 1, 15);
      pulse(4'b0001);
      check("t1_load", vol_of(0), 15);
      wait_ticks(17);
      check("t1_zero", vol_of(0), 0);
      check("t1_done", done[0], 1);
      wait_ticks(10);
      check("t1_hold", vol_of(0), 0);

      // 2: up from 8, period 3
      set_ch(1, 1, 3, 8);
      pulse(4'b0010);
      check("t2_load", vol_of(1), 8);
      wait_ticks(3);
      check("t2_first", vol_of(1), 9);
      wait_ticks(22);
      check("t2_max", vol_of(1), 15);
      check("t2_done", done[1], 1);
      wait_ticks(10);
      check("t2_nowrap", vol_of(1), 15);

      // 3: hold mode and dac_on
      set_ch(2, 1, 0, 10);
      pulse(4'b0100);
      check("t3_dac_on", dac_on[2], 1);
      wait_ticks(20);
      check("t3_hold", vol_of(2), 10);
      check("t3_done", done[2], 0);
      set_ch(2, 0, 0, 0);
      #1;
      check("t3_dac_off", dac_on[2], 0);
      @(negedge clk);

      // 4: trigger coincident with env_tick, then retrigger mid-envelope
      set_ch(0, 1, 2, 3);
      for (int i = 0; i < 2 * TD && pc != TD - 1; i++) @(negedge clk);
      check("t4_phase", pc, TD - 1);
      pulse(4'b0001);
      check("t4_load", vol_of(0), 3);
      check("t4_done", done[0], 0);
      wait_ticks(2);
      check("t4_step", vol_of(0), 4);
      set_ch(0, 0, 1, 7);
      pulse(4'b0001);
      wait_model_vol(0, 5, 20 * TD);
      check("t4_at5", vol_of(0), 5);
      set_ch(0, 0, 1, 12);
      pulse(4'b0001);
      check("t4_retrig", vol_of(0), 12);
      check("t4_retrig_done", done[0], 0);

      // 5: all channels at once, random configs and mid-envelope changes
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < NCH; c++)
            set_ch(c, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15));
         pulse('1);
         for (int i = 0; i < 100 * TD; i++) begin
            if ($urandom_range(0, 31) == 0) begin
               int c = $urandom_range(0, NCH - 1);
               set_ch(c, 1'($urandom), $urandom_range(1, 7), $urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) trigger = NCH'($urandom);
            @(negedge clk);
            trigger = '0;
         end
      end

      // 6: asynchronous reset mid-envelope
      set_ch(1, 1, 1, 4);
      pulse(4'b0010);
      wait_model_vol(1, 11, 20 * TD);
      check("t6_at_b", vol_of(1), 11);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_vol", vol_of(1), 0);
      check("t6_rst_done", done, 0);
      #1 reset = 1'b0;
      wait_ticks(10);
      check("t6_stay0", volume, 0);
      check("t6_stay_done", done, 0);
      set_ch(1, 1, 1, 6);
      pulse(4'b0010);
      check("t6_retrig", vol_of(1), 6);

      live_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
